// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: in-order pipeline scoreboard from EX to write-back.
// Tracks every issued instruction in a STAGES-deep shift register. From that
// state it derives the load-use interlock for the ID instruction, forwarding
// selects for the EX instruction, and the retiring register write.
// Optional feature: define PIPE_SB_PERF_EN to build the saturating
// issue/hazard performance counters; otherwise both outputs are tied to 0.
module pipe_scoreboard #(
   parameter int STAGES       = 3,
   parameter int NREGS        = 16,
   parameter int AW           = $clog2(NREGS),
   parameter int SW           = $clog2(STAGES),
   parameter int LD_FWD_STAGE = 2,
   parameter int FLUSH_DEPTH  = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_rs,
   input  logic [AW-1:0] issue_rt,
   input  logic          issue_rs_re,
   input  logic          issue_rt_re,
   input  logic          issue_we,
   input  logic [AW-1:0] issue_rd,
   input  logic          issue_ld,
   input  logic          mem_stall,
   input  logic          flush,
   output logic          issue_ready,
   output logic [SW-1:0] fwd_rs,
   output logic [SW-1:0] fwd_rt,
   output logic          wb_valid,
   output logic [AW-1:0] wb_rd,
   output logic          busy,
   output logic [15:0]   perf_issue,
   output logic [15:0]   perf_hazard
);

   typedef struct packed {
      logic          valid;
      logic          we;
      logic [AW-1:0] rd;
      logic          ld;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic          rs_re;
      logic          rt_re;
   } entry_t;

   entry_t pipe_q [STAGES];
   entry_t pipe_d [STAGES];
   entry_t killed [STAGES];
   entry_t new_entry;

   logic hazard;
   logic hazard_rs, hazard_rt;
   logic found_rs, found_rt;
   logic fwd_found_rs, fwd_found_rt;
   logic accept;

   // Load-use interlock: only the youngest writer of each source counts.
   // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
   always_comb begin
      hazard_rs = 1'b0;
      hazard_rt = 1'b0;
      found_rs  = 1'b0;
      found_rt  = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         if (!found_rs && pipe_q[i].valid && pipe_q[i].we && pipe_q[i].rd == issue_rs) begin
            found_rs  = 1'b1;
            hazard_rs = pipe_q[i].ld && (i + 1 < LD_FWD_STAGE);
         end
         if (!found_rt && pipe_q[i].valid && pipe_q[i].we && pipe_q[i].rd == issue_rt) begin
            found_rt  = 1'b1;
            hazard_rt = pipe_q[i].ld && (i + 1 < LD_FWD_STAGE);
         end
      end
      hazard = (issue_rs_re && issue_rs != '0 && hazard_rs) ||
               (issue_rt_re && issue_rt != '0 && hazard_rt);
   end

   assign issue_ready = !hazard && !mem_stall && !flush;
   assign accept      = issue_valid && issue_ready;

   always_comb begin
      new_entry       = '0;
      new_entry.valid = 1'b1;
      new_entry.we    = issue_we;
      new_entry.rd    = issue_rd;
      new_entry.ld    = issue_ld;
      new_entry.rs    = issue_rs;
      new_entry.rt    = issue_rt;
      new_entry.rs_re = issue_rs_re;
      new_entry.rt_re = issue_rt_re;
   end

   // Forwarding selects for the EX instruction: nearest older producer wins.
   always_comb begin
      fwd_rs       = '0;
      fwd_rt       = '0;
      fwd_found_rs = 1'b0;
      fwd_found_rt = 1'b0;
      for (int j = 1; j < STAGES; j++) begin
         if (!fwd_found_rs && pipe_q[j].valid && pipe_q[j].we && pipe_q[j].rd == pipe_q[0].rs) begin
            fwd_found_rs = 1'b1;
            fwd_rs       = SW'(j);
         end
         if (!fwd_found_rt && pipe_q[j].valid && pipe_q[j].we && pipe_q[j].rd == pipe_q[0].rt) begin
            fwd_found_rt = 1'b1;
            fwd_rt       = SW'(j);
         end
      end
      if (!(pipe_q[0].valid && pipe_q[0].rs_re && pipe_q[0].rs != '0)) fwd_rs = '0;
      if (!(pipe_q[0].valid && pipe_q[0].rt_re && pipe_q[0].rt != '0)) fwd_rt = '0;
   end

   // Next pipeline state: kill the wrong-path youngest entries, then shift unless stalled.
   always_comb begin
      killed = pipe_q;
      if (flush) begin
         for (int i = 0; i < FLUSH_DEPTH && i < STAGES; i++) killed[i] = '0;
      end
      pipe_d = killed;
      if (!mem_stall) begin
         for (int i = STAGES - 1; i > 0; i--) pipe_d[i] = killed[i-1];
         pipe_d[0] = accept ? new_entry : '0;
      end
   end

   // Pipeline state register; reset discards every in-flight entry.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign wb_valid = pipe_q[STAGES-1].valid && pipe_q[STAGES-1].we && !mem_stall;
   assign wb_rd    = pipe_q[STAGES-1].rd;

   // Occupancy: any valid entry anywhere in the tracked stages.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < STAGES; i++) busy = busy | pipe_q[i].valid;
   end

`ifdef PIPE_SB_PERF_EN
   logic [15:0] issue_cnt;
   logic [15:0] hazard_cnt;

   // Saturating issue and hazard-stall counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cnt  <= '0;
         hazard_cnt <= '0;
      end else begin
         if (accept && issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;
         if (issue_valid && hazard && !mem_stall && !flush && hazard_cnt != 16'hFFFF)
            hazard_cnt <= hazard_cnt + 16'd1;
      end
   end

   assign perf_issue  = issue_cnt;
   assign perf_hazard = hazard_cnt;
`else
   assign perf_issue  = '0;
   assign perf_hazard = '0;
`endif

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised pipeline control and scoreboard for the next-generation in-order WISC core. It tracks every instruction from EX to write-back in a STAGES-deep shift register. From that state it decides, in the same cycle, whether the ID-stage instruction may issue (load-use interlock), and it produces forwarding selects for the instruction currently in EX. Stage count, register count, load-data availability and flush depth are parameters rather than hard-wired 5-stage logic, and cache stall, branch flush and write-back tracking are handled in one block.

## Interface
- STAGES, 3, tracked stages after ID (index 0 = EX, STAGES-1 = WB); legal range 2..8
- NREGS, 16, architectural registers; register 0 is hard-wired zero
- AW, $clog2(NREGS), register address width
- SW, $clog2(STAGES), stage-index width
- LD_FWD_STAGE, 2, first stage index at which load data is forwardable; legal range 1..STAGES-1
- FLUSH_DEPTH, 1, number of youngest stages (indices 0..FLUSH_DEPTH-1) killed by flush
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  ID holds an instruction requesting issue
- issue_rs, issue_rt  in  AW  source register addresses
- issue_rs_re, issue_rt_re  in  1  source actually read
- issue_we  in  1  instruction writes a register
- issue_rd  in  AW  destination address
- issue_ld  in  1  instruction is a load
- mem_stall  in  1  cache not ready; freezes all tracked stages
- flush  in  1  branch/jump flush
- issue_ready  out  1  issue permitted this cycle
- fwd_rs, fwd_rt  out  SW  forwarding source for the EX instruction: 0 = register file, j = stage j
- wb_valid  out  1  register write retiring this cycle
- wb_rd  out  AW  retiring destination
- busy  out  1  any valid entry tracked
- perf_issue, perf_hazard  out  16  performance counters (see Configuration)

## Operation
- Entry fields: valid, we, rd, ld, rs, rt, rs_re, rt_re.
- hazard: true when, for a read source s with s != 0, the youngest valid entry at index i with we and rd == s has ld=1 and i+1 < LD_FWD_STAGE. Older matches are ignored.
- issue_ready = !hazard && !mem_stall && !flush.
- accept = issue_valid && issue_ready.
- When mem_stall=0 and flush=0:
  - entries shift by one; index STAGES-1 retires.
  - index 0 is loaded with the issuing instruction if accept is true, otherwise with a bubble (valid=0).
- When mem_stall=1 and flush=0: every entry holds; there is no shift, no issue and no retire.
- When flush=1:
  - entries at indices < FLUSH_DEPTH are cleared; this applies on top of the shift if mem_stall=0 and in place if mem_stall=1.
  - When mem_stall=0, index 0 is loaded with a bubble; nothing issues.
  - Entries at indices >= FLUSH_DEPTH survive.
- Forwarding: fwd_rs is the smallest j in 1..STAGES-1 such that entry j is valid, has we, rd == entry0.rs, rs != 0, and entry 0 is valid with rs_re. If no entry matches, fwd_rs = 0. fwd_rt is computed the same way from rt.
- wb_valid = entry[STAGES-1].valid && entry[STAGES-1].we && !mem_stall.
- wb_rd = entry[STAGES-1].rd.
- busy = OR of all valid bits.
- Register 0 never creates a hazard or a forward.

## Timing
- Reset: all valid=0. Hence issue_ready=1 (given no stall/flush), fwd_rs=fwd_rt=0, wb_valid=0, busy=0, and counters read 0.
- rst asserted mid-operation discards all in-flight entries at the next edge. rst has priority over mem_stall and flush.
- issue_ready, hazard, fwd_*, wb_* are combinational from registered state plus the current inputs; there is no same-cycle loop through issue_valid.
- An instruction accepted at edge n sits at index 0 after edge n and reaches WB after STAGES-1 further unstalled edges.
- Load-use with default parameters gives exactly one bubble, after which fwd = 2.
- With flush and mem_stall both high, entries are killed but nothing shifts.

## Configuration
- PIPE_SB_PERF_EN defined: two 16-bit counters, both cleared by rst.
  - perf_issue increments on each accept.
  - perf_hazard increments on each cycle with issue_valid && hazard && !mem_stall && !flush.
  - Both saturate at 16'hFFFF.
- PIPE_SB_PERF_EN undefined: the counters are not built; perf_issue and perf_hazard are tied to 0.

## Test plan
- Reset mid-flight: load 3 instructions, assert rst 1 cycle → busy=0, wb_valid=0, issue_ready=1, perf counters 0.
- ALU dependency: issue we rd=3, then rs=3 next cycle → issue_ready=1 both cycles; fwd_rs=1 once the consumer is in EX.
- Load-use: ld rd=5, then rs=5 → issue_ready=0 for exactly 1 cycle, then accept; fwd_rs=2; perf_hazard=1.
- Cache stall: 2 entries in flight, mem_stall=1 for 3 cycles → no shift, wb_valid=0; after release, retirement resumes in original order.
- Flush: entry at index 0 (we rd=7) plus flush=1 → the entry never produces wb_valid; issue_ready=0 that cycle; the older entry still retires.
- Register 0: ld rd=0 followed by rs=0 → no stall, fwd_rs=0.
